exec_adjust_seq: RTL and testbench
==================================

Name: exec_adjust_seq

Overview:
- Sequenced BCD/ASCII adjust unit for the execute stage of the 8086-class core.
- Handles DAA, DAS, AAA and AAS in a single cycle.
- Runs AAM as an 8-iteration restoring divide and AAD as an 8-iteration shift-add multiply. This replaces the combinational compare ladder and multiplier with a small iterative datapath.
- Uses a start/busy/done handshake with the execute-stage microsequencer, plus an abort input for pipeline flush.

Parameters:
- ITER, 8, number of AAM/AAD iteration cycles; must equal the operand width of 8.

Ports:
- iClk  input  1  core clock
- iRst_n  input  1  asynchronous active-low reset
- iStart  input  1  request; accepted only in IDLE
- iAbort  input  1  flush; returns to IDLE, no done
- iFunc  input  3  000 DAA, 001 DAS, 010 AAA, 011 AAS, 10x AAM, 11x AAD
- iAX  input  16  AX operand, sampled on accept
- iImm  input  8  AAM/AAD base (normally 0x0A), sampled on accept
- iCarry  input  1  CF in
- iAux  input  1  AF in
- oBusy  output  1  high in CALC and DONE
- oDone  output  1  one-cycle pulse; result valid
- oAX  output  16  result AX
- oCF, oAF, oSF, oZF, oPF  output  1 each  result flags
- oDivErr  output  1  AAM with base 0 (#DE); valid with oDone

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE.
  - All outputs 0.
  - Iteration counter, remainder, quotient and accumulator registers 0.
- States: IDLE, CALC, DONE.
- Accept condition: iStart=1 && iAbort=0 in IDLE. On accept, latch iFunc/iAX/iImm/iCarry/iAux.
- Single-cycle ops (DAA/DAS/AAA/AAS) go IDLE->DONE:
  - Result registered on the accept edge.
  - oDone high on the cycle after accept (latency 1).
- DAA:
  - If AL[3:0]>9 or AF: AL+=6 and AF=1, else AF=0.
  - If the original AL>0x99 or CF: AL+=0x60 and CF=1, else CF=0.
  - AH unchanged.
- DAS: same as DAA, with subtraction.
- AAA/AAS:
  - If AL[3:0]>9 or AF: AL[3:0]±=6 (mod 16), AH±=1, AF=CF=1.
  - Else AF=CF=0.
  - AL[7:4]=0 in both cases.
  - SF/ZF/PF unchanged (0 held from the previous result is acceptable; the bench does not check them).
- AAM with iImm=0: IDLE->DONE, oDivErr=1, oAX=iAX, and all flag outputs take their inputs (SF/ZF/PF computed from iAX[7:0]).
- AAM with iImm!=0: IDLE->CALC.
  - 8 cycles of restoring divide of AL by imm, MSB first.
  - Remainder register is 9 bits. Each cycle: rem={rem[7:0],dividend_msb}; if rem>=imm, subtract imm and shift in quotient bit 1.
  - CALC->DONE when the counter reaches 7.
  - Result: AH=quotient, AL=remainder.
- AAD: IDLE->CALC.
  - 8 cycles of shift-add of AH*imm, LSB of AH first, accumulator 8 bits (mod 256).
  - On the CALC->DONE edge: AL=(acc+AL) mod 256, AH=0.
- AAM/AAD timing and flags:
  - oDone is asserted exactly ITER+1=9 cycles after the accept edge.
  - CF=AF=0.
- Status flags:
  - SF=AL[7], ZF=(AL==0), PF=~^AL, computed from the result AL for DAA, DAS, AAM and AAD.
- DONE:
  - Lasts exactly 1 cycle, then goes to IDLE.
  - oDone is high only in DONE.
  - Result outputs and oDivErr hold until the next accept.
  - oDivErr clears on the next accept.
- Start rules:
  - iStart while oBusy=1 is ignored. No queuing.
  - A new start is accepted in the cycle after DONE.
- iAbort:
  - In CALC or DONE: next state IDLE, oDone suppressed (forced 0 in DONE), result outputs unchanged from the previous completed op.
  - iAbort has priority over iStart in the same cycle.
- Arithmetic: all arithmetic is modulo the field width; no overflow indication. OF is not produced.

Test Plan:
- DAA, iAX=0x007D, CF=0, AF=0 -> oDone at cycle 1; oAX=0x0083, AF=1, CF=0, SF=1, ZF=0, PF=0.
- AAA, iAX=0x010F, AF=0 -> oAX=0x0205, AF=1, CF=1, latency 1. DAS, iAX=0x00A0, CF=0 -> oAX=0x0040, CF=1, AF=0.
- AAM, iAX=0x0041, iImm=0x0A -> oBusy high for 9 cycles, oDone at cycle 9; oAX=0x0605, SF=0, ZF=0, PF=1, CF=AF=0, oDivErr=0.
- AAM, iImm=0x00, iAX=0x1234 -> oDone at cycle 1, oDivErr=1, oAX=0x1234. Next AAM with iImm=0x0A accepted and oDivErr returns to 0.
- AAD, iAX=0x0705, iImm=0x0A -> oAX=0x004B, PF=1, at cycle 9. AAD, iAX=0xFFFF, iImm=0xFF -> oAX=0x0000, ZF=1, PF=1.
- AAM started, iAbort at cycle 4 -> no oDone, oBusy low at cycle 5, oAX keeps its prior value. iStart during CALC ignored. Async reset asserted mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/exec_adjust_seq.sv
// BCD/ASCII adjust unit: DAA/DAS/AAA/AAS finish in one cycle.
// AAM runs as an iterative restoring divide and AAD as an iterative shift-add multiply.
module exec_adjust_seq #(
  parameter int ITER = 8
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [2:0]  iFunc,
  input  logic [15:0] iAX,
  input  logic [7:0]  iImm,
  input  logic        iCarry,
  input  logic        iAux,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oAX,
  output logic        oCF,
  output logic        oAF,
  output logic        oSF,
  output logic        oZF,
  output logic        oPF,
  output logic        oDivErr
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_aad;
  logic [8:0]      rem;
  logic [7:0]      quo;
  logic [7:0]      acc;
  logic [7:0]      opr;
  logic [7:0]      mcand;
  logic [7:0]      imm_r;
  logic [7:0]      al_r;

  logic [15:0]     ax_q;
  logic            cf_q, af_q, sf_q, zf_q, pf_q, de_q, done_q;

  function automatic logic parity_even(input logic [7:0] v);
    return ~^v;
  endfunction

  // single-cycle adjust results, evaluated directly from the request inputs
  logic [7:0] al_in, ah_in, s_al, s_ah;
  logic       lo_adj, hi_adj, s_cf, s_af;

  always_comb begin
    al_in  = iAX[7:0];
    ah_in  = iAX[15:8];
    lo_adj = (al_in[3:0] > 4'd9) || iAux;
    hi_adj = (al_in > 8'h99) || iCarry;
    s_al   = al_in;
    s_ah   = ah_in;
    s_cf   = iCarry;
    s_af   = iAux;
    case (iFunc)
      3'b000: begin
        s_al = al_in + (lo_adj ? 8'h06 : 8'h00) + (hi_adj ? 8'h60 : 8'h00);
        s_af = lo_adj;
        s_cf = hi_adj;
      end
      3'b001: begin
        s_al = al_in - (lo_adj ? 8'h06 : 8'h00) - (hi_adj ? 8'h60 : 8'h00);
        s_af = lo_adj;
        s_cf = hi_adj;
      end
      3'b010: begin
        s_al = {4'h0, lo_adj ? al_in[3:0] + 4'd6 : al_in[3:0]};
        s_ah = lo_adj ? ah_in + 8'd1 : ah_in;
        s_af = lo_adj;
        s_cf = lo_adj;
      end
      3'b011: begin
        s_al = {4'h0, lo_adj ? al_in[3:0] - 4'd6 : al_in[3:0]};
        s_ah = lo_adj ? ah_in - 8'd1 : ah_in;
        s_af = lo_adj;
        s_cf = lo_adj;
      end
      default: begin
        s_al = al_in;
        s_ah = ah_in;
      end
    endcase
  end

  // one iteration of the divide / multiply datapath
  logic [8:0] rem_sh, rem_nx;
  logic       rem_ge;
  logic [7:0] quo_nx, acc_nx, aad_al;

  always_comb begin
    rem_sh = (rem << 1) | 9'(opr[7]);
    rem_ge = rem_sh >= {1'b0, imm_r};
    rem_nx = rem_ge ? rem_sh - {1'b0, imm_r} : rem_sh;
    quo_nx = {quo[6:0], rem_ge};
    acc_nx = opr[0] ? acc + mcand : acc;
    aad_al = acc_nx + al_r;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_aad <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      acc    <= '0;
      opr    <= '0;
      mcand  <= '0;
      imm_r  <= '0;
      al_r   <= '0;
      ax_q   <= '0;
      cf_q   <= 1'b0;
      af_q   <= 1'b0;
      sf_q   <= 1'b0;
      zf_q   <= 1'b0;
      pf_q   <= 1'b0;
      de_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iStart && !iAbort) begin
            de_q   <= 1'b0;
            imm_r  <= iImm;
            al_r   <= iAX[7:0];
            is_aad <= iFunc[1];
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            acc    <= '0;
            if (!iFunc[2]) begin
              ax_q   <= {s_ah, s_al};
              cf_q   <= s_cf;
              af_q   <= s_af;
              if (!iFunc[1]) begin
                sf_q <= s_al[7];
                zf_q <= (s_al == 8'h00);
                pf_q <= parity_even(s_al);
              end
              done_q <= 1'b1;
              state  <= S_DONE;
            end else if (!iFunc[1] && iImm == 8'h00) begin
              ax_q   <= iAX;
              cf_q   <= iCarry;
              af_q   <= iAux;
              sf_q   <= iAX[7];
              zf_q   <= (iAX[7:0] == 8'h00);
              pf_q   <= parity_even(iAX[7:0]);
              de_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              opr   <= iFunc[1] ? iAX[15:8] : iAX[7:0];
              mcand <= iImm;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (iAbort) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (is_aad) begin
              acc   <= acc_nx;
              opr   <= opr >> 1;
              mcand <= mcand << 1;
            end else begin
              rem <= rem_nx;
              quo <= quo_nx;
              opr <= opr << 1;
            end
            if (cnt == LAST) begin
              cf_q   <= 1'b0;
              af_q   <= 1'b0;
              if (is_aad) begin
                ax_q <= {8'h00, aad_al};
                sf_q <= aad_al[7];
                zf_q <= (aad_al == 8'h00);
                pf_q <= parity_even(aad_al);
              end else begin
                ax_q <= {quo_nx, rem_nx[7:0]};
                sf_q <= rem_nx[7];
                zf_q <= (rem_nx[7:0] == 8'h00);
                pf_q <= parity_even(rem_nx[7:0]);
              end
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // a flush during the completion cycle swallows the done pulse
  assign oDone   = done_q & ~iAbort;
  assign oBusy   = (state != S_IDLE);
  assign oAX     = ax_q;
  assign oCF     = cf_q;
  assign oAF     = af_q;
  assign oSF     = sf_q;
  assign oZF     = zf_q;
  assign oPF     = pf_q;
  assign oDivErr = de_q;

endmodule

// File: tb/tb_exec_adjust_seq.sv
// Scoreboard bench for exec_adjust_seq: directed cases, randomized ops, abort and async reset.
module tb_exec_adjust_seq;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b1;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic [2:0]  iFunc = '0;
  logic [15:0] iAX = '0;
  logic [7:0]  iImm = '0;
  logic        iCarry = 1'b0;
  logic        iAux = 1'b0;
  logic        oBusy, oDone, oCF, oAF, oSF, oZF, oPF, oDivErr;
  logic [15:0] oAX;

  exec_adjust_seq #(.ITER(8)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort),
    .iFunc(iFunc), .iAX(iAX), .iImm(iImm), .iCarry(iCarry), .iAux(iAux),
    .oBusy(oBusy), .oDone(oDone), .oAX(oAX), .oCF(oCF), .oAF(oAF),
    .oSF(oSF), .oZF(oZF), .oPF(oPF), .oDivErr(oDivErr)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ax;
    logic        cf, af, sf, zf, pf, de, szp;
    int          lat;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model straight from the instruction definitions
  function automatic exp_t model(input logic [2:0] f, input logic [15:0] ax,
                                 input logic [7:0] imm, input logic cf, input logic af);
    exp_t e;
    int al, ah, lo;
    logic [7:0] r8;
    al = int'(ax[7:0]);
    ah = int'(ax[15:8]);
    e.ax = '0; e.cf = 1'b0; e.af = 1'b0; e.sf = 1'b0; e.zf = 1'b0; e.pf = 1'b0;
    e.de = 1'b0; e.szp = 1'b1; e.lat = 1; e.due = 0;
    case (f)
      3'd0, 3'd1: begin
        lo = al;
        if ((al % 16) > 9 || af) begin
          lo = (f == 3'd0) ? lo + 6 : lo - 6;
          e.af = 1'b1;
        end
        if (al > 'h99 || cf) begin
          lo = (f == 3'd0) ? lo + 'h60 : lo - 'h60;
          e.cf = 1'b1;
        end
        al = lo & 255;
      end
      3'd2, 3'd3: begin
        e.szp = 1'b0;
        if ((al % 16) > 9 || af) begin
          lo = (f == 3'd2) ? (al % 16) + 6 : (al % 16) - 6;
          ah = (f == 3'd2) ? ah + 1 : ah - 1;
          e.af = 1'b1;
          e.cf = 1'b1;
        end else begin
          lo = al % 16;
        end
        al = lo & 15;
        ah = ah & 255;
      end
      3'd4, 3'd5: begin
        if (imm == 8'h00) begin
          e.de = 1'b1;
          e.cf = cf;
          e.af = af;
        end else begin
          lo = al / int'(imm);
          al = al % int'(imm);
          ah = lo;
          e.lat = 9;
        end
      end
      default: begin
        al = (ah * int'(imm) + al) % 256;
        ah = 0;
        e.lat = 9;
      end
    endcase
    r8 = 8'(al);
    e.ax = {8'(ah), r8};
    e.sf = r8[7];
    e.zf = (al == 0);
    e.pf = ($countones(r8) % 2) == 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  exp_t got;
  always @(negedge iClk) begin
    if (iRst_n && oDone) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        got = sbq.pop_front();
        chk("ax", 32'(oAX), 32'(got.ax));
        chk("cf", 32'(oCF), 32'(got.cf));
        chk("af", 32'(oAF), 32'(got.af));
        chk("diverr", 32'(oDivErr), 32'(got.de));
        if (got.szp) begin
          chk("sf", 32'(oSF), 32'(got.sf));
          chk("zf", 32'(oZF), 32'(got.zf));
          chk("pf", 32'(oPF), 32'(got.pf));
        end
        chk("latency", 32'(cyc), 32'(got.due));
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [15:0] ax, input logic [7:0] imm,
                       input logic cf, input logic af, input int junk_at, input int abort_at);
    exp_t e;
    int bc;
    logic [15:0] prev_ax;
    e = model(f, ax, imm, cf, af);
    @(negedge iClk);
    iFunc = f; iAX = ax; iImm = imm; iCarry = cf; iAux = af; iStart = 1'b1;
    prev_ax = oAX;
    e.due = cyc + e.lat;
    if (abort_at == 0) sbq.push_back(e);
    bc = 0;
    for (int k = 1; k <= e.lat; k++) begin
      @(negedge iClk);
      iStart = (k == junk_at);
      if (k == junk_at) begin
        iFunc = 3'(k); iAX = 16'($urandom); iImm = 8'($urandom); iCarry = 1'b1; iAux = 1'b1;
      end
      iAbort = (k == abort_at);
      if (oBusy) bc++;
      if (abort_at > 0 && k == abort_at + 1) begin
        chk("abort_busy", 32'(oBusy), 32'd0);
        chk("abort_ax_held", 32'(oAX), 32'(prev_ax));
        break;
      end
    end
    iStart = 1'b0;
    iAbort = 1'b0;
    if (abort_at == 0) chk("busy_cycles", 32'(bc), 32'(e.lat));
  endtask

  initial begin
    #1 iRst_n = 1'b0;
    #2 chk("reset_outputs",
           32'({oBusy, oDone, oAX, oCF, oAF, oSF, oZF, oPF, oDivErr}), 32'd0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;

    do_op(3'b000, 16'h007D, 8'h0A, 1'b0, 1'b0, 0, 0);
    chk("daa_ax", 32'(oAX), 32'h0083);
    chk("daa_flags", 32'({oCF, oAF, oSF, oZF, oPF}), 32'b01100);
    do_op(3'b010, 16'h010F, 8'h0A, 1'b0, 1'b0, 0, 0);
    chk("aaa_ax", 32'(oAX), 32'h0205);
    do_op(3'b001, 16'h00A0, 8'h0A, 1'b0, 1'b0, 0, 0);
    chk("das_ax", 32'(oAX), 32'h0040);
    do_op(3'b100, 16'h0041, 8'h0A, 1'b0, 1'b0, 0, 0);
    chk("aam_ax", 32'(oAX), 32'h0605);
    chk("aam_flags", 32'({oCF, oAF, oSF, oZF, oPF, oDivErr}), 32'b000010);
    do_op(3'b100, 16'h1234, 8'h00, 1'b1, 1'b0, 0, 0);
    chk("aam0_de", 32'({oDivErr, oAX}), 32'h11234);
    do_op(3'b101, 16'h0041, 8'h0A, 1'b0, 1'b0, 3, 0);
    chk("aam_de_clear", 32'(oDivErr), 32'd0);
    do_op(3'b110, 16'h0705, 8'h0A, 1'b0, 1'b0, 0, 0);
    chk("aad_ax", 32'({oAX, oPF}), 32'h0000_0097);
    do_op(3'b111, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 5, 0);
    chk("aad_wrap", 32'({oAX, oZF, oPF}), 32'd3);

    // flushed AAM leaves the last completed result in place
    do_op(3'b000, 16'h007D, 8'h0A, 1'b0, 1'b0, 0, 0);
    do_op(3'b100, 16'h0041, 8'h0A, 1'b0, 1'b0, 0, 4);
    repeat (12) @(negedge iClk);
    chk("abort_no_done_ax", 32'(oAX), 32'h0083);

    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [7:0] imm;
      sel = int'($urandom_range(0, 3));
      imm = (sel == 0) ? 8'h00 : (sel == 1) ? 8'($urandom) : 8'h0A;
      do_op(3'($urandom_range(0, 7)), 16'($urandom), imm, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 6)), 0);
    end

    // asynchronous reset in the middle of an iteration
    do_op(3'b000, 16'h007D, 8'h0A, 1'b0, 1'b0, 0, 0);
    @(negedge iClk);
    iFunc = 3'b100; iAX = 16'h00C8; iImm = 8'h0A; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (2) @(negedge iClk);
    #2 iRst_n = 1'b0;
    #1 chk("async_reset_mid_calc",
           32'({oBusy, oDone, oAX, oCF, oAF, oSF, oZF, oPF, oDivErr}), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    do_op(3'b110, 16'h0705, 8'h0A, 1'b0, 1'b0, 0, 0);

    repeat (12) @(negedge iClk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
